// File: rtl/csa_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 forms per-block candidate sums; stage 2 resolves the block carries and selects.
module csa_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             co,
    output logic             ovf
);

    localparam int NB = WIDTH / BLK;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_sum0;
    logic [WIDTH-1:0] s1_sum1;
    logic [NB-1:0]    s1_c0;
    logic [NB-1:0]    s1_c1;
    logic             s1_xm;
    logic             s1_ybm;

    logic [WIDTH-1:0] yb;
    logic             cin;
    logic [WIDTH-1:0] sum0_n;
    logic [WIDTH-1:0] sum1_n;
    logic [NB-1:0]    c0_n;
    logic [NB-1:0]    c1_n;
    logic [BLK:0]     t0;
    logic [BLK:0]     t1;

    logic [WIDTH-1:0] z_n;
    logic             co_n;
    logic             ovf_n;
    logic             cprev;

    logic             s2_load;
    logic             s1_adv;
    logic             in_fire;

    assign s2_load  = ~out_valid | out_ready;
    assign s1_adv   = s1_valid & s2_load;
    assign in_ready = ~s1_valid | s2_load;
    assign in_fire  = in_valid & in_ready;

    // Block 0 gets the real carry-in for both candidates, so stage 2 can treat all blocks alike.
    always_comb begin
        yb     = sub ? ~y : y;
        cin    = sub | ci;
        sum0_n = '0;
        sum1_n = '0;
        c0_n   = '0;
        c1_n   = '0;
        t0     = '0;
        t1     = '0;
        for (int j = 0; j < NB; j++) begin
            t0 = {1'b0, x[j*BLK +: BLK]} + {1'b0, yb[j*BLK +: BLK]}
                 + {{BLK{1'b0}}, (j == 0) & cin};
            t1 = {1'b0, x[j*BLK +: BLK]} + {1'b0, yb[j*BLK +: BLK]}
                 + {{BLK{1'b0}}, (j == 0) ? cin : 1'b1};
            sum0_n[j*BLK +: BLK] = t0[BLK-1:0];
            sum1_n[j*BLK +: BLK] = t1[BLK-1:0];
            c0_n[j]              = t0[BLK];
            c1_n[j]              = t1[BLK];
        end
    end

    always_comb begin
        z_n   = '0;
        cprev = 1'b0;
        for (int j = 0; j < NB; j++) begin
            z_n[j*BLK +: BLK] = cprev ? s1_sum1[j*BLK +: BLK] : s1_sum0[j*BLK +: BLK];
            cprev             = s1_c0[j] | (s1_c1[j] & cprev);
        end
        co_n  = cprev;
        ovf_n = (s1_xm == s1_ybm) & (z_n[WIDTH-1] != s1_xm);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_valid <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_c0    <= '0;
            s1_c1    <= '0;
            s1_xm    <= 1'b0;
            s1_ybm   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sum0  <= sum0_n;
            s1_sum1  <= sum1_n;
            s1_c0    <= c0_n;
            s1_c1    <= c1_n;
            s1_xm    <= x[WIDTH-1];
            s1_ybm   <= yb[WIDTH-1];
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result registers only change on a real load, so a stalled output stays put.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            z         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                z   <= z_n;
                co  <= co_n;
                ovf <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe.sv
// Self-checking bench for csa_pipe: directed vectors, backpressure, reset and random traffic
// against an arithmetic reference model, plus parameter sweeps on small instances.
module tb_csa_pipe;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [15:0] x = '0, y = '0, z;
    logic        ci = 1'b0, sub = 1'b0, co, ovf;

    logic       sv_valid = 1'b0, sv_ready = 1'b1;
    logic [4:0] x5 = '0, y5 = '0, z5;
    logic [5:0] x6 = '0, y6 = '0, z6;
    logic [7:0] x8 = '0, y8 = '0, z8;
    logic       ci5 = 1'b0, sub5 = 1'b0, rdy5, ov5, co5, ovf5;
    logic       ci6 = 1'b0, sub6 = 1'b0, rdy6, ov6, co6, ovf6;
    logic       ci8 = 1'b0, sub8 = 1'b0, rdy8, ov8, co8, ovf8;

    csa_pipe #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .co(co), .ovf(ovf));

    csa_pipe #(.WIDTH(5), .BLK(5)) dut5 (
        .clk(clk), .rst_b(rst_b), .in_valid(sv_valid), .in_ready(rdy5),
        .x(x5), .y(y5), .ci(ci5), .sub(sub5), .out_valid(ov5), .out_ready(sv_ready),
        .z(z5), .co(co5), .ovf(ovf5));

    csa_pipe #(.WIDTH(6), .BLK(2)) dut6 (
        .clk(clk), .rst_b(rst_b), .in_valid(sv_valid), .in_ready(rdy6),
        .x(x6), .y(y6), .ci(ci6), .sub(sub6), .out_valid(ov6), .out_ready(sv_ready),
        .z(z6), .co(co6), .ovf(ovf6));

    csa_pipe #(.WIDTH(8), .BLK(1)) dut8 (
        .clk(clk), .rst_b(rst_b), .in_valid(sv_valid), .in_ready(rdy8),
        .x(x8), .y(y8), .ci(ci8), .sub(sub8), .out_valid(ov8), .out_ready(sv_ready),
        .z(z8), .co(co8), .ovf(ovf8));

    typedef struct { longint z; bit co; bit ovf; } exp_t;
    typedef struct { exp_t e5; exp_t e6; exp_t e8; } sexp_t;
    typedef struct {
        logic [15:0] x; logic [15:0] y; logic ci; logic sub;
        logic [15:0] ez; logic eco; logic eovf;
    } vec_t;

    exp_t  q[$];
    sexp_t qs[$];
    int n_cmp = 0, n_bad = 0, n_printed = 0;
    int n_acc = 0, n_res = 0, ns_res = 0;

    // Reference: plain integer arithmetic on the operands, signed range check for overflow.
    function automatic exp_t refModel(input int w, input longint a, input longint b,
                                      input bit c, input bit s);
        exp_t r;
        longint m, half, full, sa, sb, sr;
        m    = longint'(1) << w;
        half = m / 2;
        full = s ? (a - b + m) : (a + b + longint'(c));
        r.z  = full % m;
        r.co = (full >= m);
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        sr   = s ? (sa - sb) : (sa + sb + longint'(c));
        r.ovf = (sr < -half) || (sr >= half);
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_printed < 40) begin
                n_printed++;
                $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
        x = a; y = b; ci = c; sub = s; in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (rst_b) begin
            if (out_valid && out_ready) begin
                n_res++;
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("[TB] FAIL sb_extra: got result %0h, expected none", z);
                end else begin
                    e = q.pop_front();
                    checkOutput("sb_z", z, e.z);
                    checkOutput("sb_co", co, longint'(e.co));
                    checkOutput("sb_ovf", ovf, longint'(e.ovf));
                end
            end
            if (in_valid && in_ready) begin
                n_acc++;
                q.push_back(refModel(16, x, y, ci, sub));
            end
        end
    end

    always @(negedge clk) begin : mon_sweep
        sexp_t se;
        if (rst_b) begin
            if (ov5 && sv_ready) begin
                ns_res++;
                if (qs.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("[TB] FAIL sweep_extra: got result %0h, expected none", z5);
                end else begin
                    se = qs.pop_front();
                    checkOutput("w5_z", z5, se.e5.z);
                    checkOutput("w5_co", co5, longint'(se.e5.co));
                    checkOutput("w5_ovf", ovf5, longint'(se.e5.ovf));
                    checkOutput("w6_valid", ov6, 1);
                    checkOutput("w6_z", z6, se.e6.z);
                    checkOutput("w6_co", co6, longint'(se.e6.co));
                    checkOutput("w6_ovf", ovf6, longint'(se.e6.ovf));
                    checkOutput("w8_valid", ov8, 1);
                    checkOutput("w8_z", z8, se.e8.z);
                    checkOutput("w8_co", co8, longint'(se.e8.co));
                    checkOutput("w8_ovf", ovf8, longint'(se.e8.ovf));
                end
            end
            if (sv_valid && rdy5) begin
                se.e5 = refModel(5, x5, y5, ci5, sub5);
                se.e6 = refModel(6, x6, y6, ci6, sub6);
                se.e8 = refModel(8, x8, y8, ci8, sub8);
                qs.push_back(se);
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        vec_t tbl[8];
        exp_t ea, eb, ec, er;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[6] = '{16'h0007, 16'h0007, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Power-on reset
        #1 rst_b = 1'b0;
        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_z", z, 0);
        checkOutput("rst_co", co, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_valid", out_valid, 0);
        tick();

        // Directed vectors with latency check
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            applyStimulus(tbl[i].x, tbl[i].y, tbl[i].ci, tbl[i].sub);
            @(negedge clk);
            checkOutput("tbl_in_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            checkOutput("tbl_early_valid", out_valid, 0);
            tick();
            @(negedge clk);
            checkOutput("tbl_out_valid", out_valid, 1);
            checkOutput("tbl_z", z, tbl[i].ez);
            checkOutput("tbl_co", co, tbl[i].eco);
            checkOutput("tbl_ovf", ovf, tbl[i].eovf);
            tick();
        end

        // Backpressure: capacity of two, stable output, in-order release
        ea = refModel(16, 16'h1111, 16'h2222, 1'b0, 1'b0);
        eb = refModel(16, 16'hF000, 16'h1000, 1'b1, 1'b0);
        ec = refModel(16, 16'h0003, 16'h0009, 1'b0, 1'b1);
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_ready_a", in_ready, 1);
        tick();
        applyStimulus(16'hF000, 16'h1000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_ready_b", in_ready, 1);
        tick();
        applyStimulus(16'h0003, 16'h0009, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("bp_ready_c", in_ready, 0);
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_hold_z", z, ea.z);
        tick();
        @(negedge clk);
        checkOutput("bp_ready_c2", in_ready, 0);
        checkOutput("bp_hold_z2", z, ea.z);
        checkOutput("bp_hold_co", co, longint'(ea.co));
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_release", in_ready, 1);
        checkOutput("bp_order_a", z, ea.z);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_order_b_valid", out_valid, 1);
        checkOutput("bp_order_b", z, eb.z);
        tick();
        @(negedge clk);
        checkOutput("bp_order_c_valid", out_valid, 1);
        checkOutput("bp_order_c", z, ec.z);
        checkOutput("bp_order_c_co", co, longint'(ec.co));
        tick();
        @(negedge clk);
        checkOutput("bp_empty", out_valid, 0);
        tick();

        // Full throughput: one result every cycle
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            @(negedge clk);
            checkOutput("tp_in_ready", in_ready, 1);
            if (i > 1) checkOutput("tp_out_valid", out_valid, 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("tp_tail1", out_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("tp_tail2", out_valid, 1);
        tick();
        @(negedge clk);
        checkOutput("tp_done", out_valid, 0);
        tick();

        // Random valid/ready toggling
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            x   = 16'($urandom);
            y   = 16'($urandom);
            ci  = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rand_drain_empty", q.size(), 0);
        checkOutput("rand_acc_vs_res", n_res, n_acc);

        // Asynchronous reset with two operations in flight
        out_ready = 1'b0;
        applyStimulus(16'h4000, 16'h0123, 1'b0, 1'b0);
        tick();
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput("pre_rst_valid", out_valid, 1);
        #2 rst_b = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_z", z, 0);
        checkOutput("mid_rst_co", co, 0);
        checkOutput("mid_rst_ovf", ovf, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        q.delete();
        n_acc = 0;
        n_res = 0;
        tick();
        rst_b = 1'b1;
        out_ready = 1'b1;
        er = refModel(16, 16'h00A5, 16'h005A, 1'b1, 1'b0);
        applyStimulus(16'h00A5, 16'h005A, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("after_rst_in_ready", in_ready, 1);
        checkOutput("after_rst_idle", out_valid, 0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_no_stale", out_valid, 0);
        tick();
        @(negedge clk);
        checkOutput("after_rst_valid", out_valid, 1);
        checkOutput("after_rst_z", z, er.z);
        tick();

        // Parameter sweep on the small instances
        sv_ready = 1'b1;
        sv_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            x5 = i[4:0];  y5 = i[9:5];   ci5 = i[10]; sub5 = i[11];
            x6 = i[5:0];  y6 = i[11:6];  ci6 = i[12]; sub6 = i[13];
            x8 = i[7:0];  y8 = i[15:8];
            ci8  = 1'($urandom_range(0, 1));
            sub8 = 1'($urandom_range(0, 1));
            tick();
        end
        sv_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("sweep_drain_empty", qs.size(), 0);
        checkOutput("sweep_count", ns_res, 65536);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
